mc_ctrl: RTL and testbench
==========================

# mc_ctrl

Multi-cycle control unit for the CPU datapath: a Moore/Mealy state machine that sequences one instruction over several cycles through a single shared memory port, ALU and register file. It decodes `INSTop`/`funct`, waits on a memory ready handshake, and drives every datapath enable, mux select and ALU `opcode`. It replaces the single-cycle `CTRL` when the core is rebuilt around one memory and internal IR/A/B/ALUOut/MDR registers.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `INSTop` in 6: opcode field from the IR.
- `funct` in 6: function field from the IR.
- `Zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory has completed the current access this cycle.
- `mem_req` out 1: memory access request, held until `mem_ready`.
- `MemRead`, `MemWrite` out 1: access type, valid while `mem_req`=1.
- `IorD` out 1: address mux; 0 = PC, 1 = ALUOut.
- `IRWrite` out 1: load the IR.
- `PCWrite` out 1: load the PC; already includes the branch condition.
- `PCSource` out 2: PC mux; 00 = ALU, 01 = ALUOut, 10 = `{PC[31:28],jAddr,2'b00}`.
- `ALUSrcA` out 1: 0 = PC, 1 = A.
- `ALUSrcB` out 2: 00 = B, 01 = 4, 10 = Imm32, 11 = Imm32<<2.
- `opcode` out 3: ALU operation; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
- `RegDst` out 1: 0 = rt, 1 = rd.
- `MemtoReg` out 1: 0 = ALUOut, 1 = MDR.
- `RegWrite` out 1: register file write enable.
- `EXTOp` out 1: 1 = sign extend, 0 = zero extend.
- `illegal` out 1: one-cycle pulse for an unsupported opcode or funct.
- `instr_cnt`, `cycle_cnt` out 32: performance counters (see Configuration).

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEXE, RTWB, IEXE, IWB, BEQ, JMP.
- All outputs not listed for a state are 0.
- **FETCH**
  - Drives `mem_req`=1, `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `opcode`=ADD, `PCSource`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready` (Mealy).
  - On `mem_ready`, go to DECODE; otherwise stay.
- **DECODE**
  - Drives `ALUSrcA`=0, `ALUSrcB`=11, `opcode`=ADD, `EXTOp`=1 (branch target into ALUOut).
  - Dispatch on `INSTop`:
    - 0x00 with valid `funct` → RTEXE.
    - 0x23 (lw) or 0x2B (sw) → MEMADR.
    - 0x08 (addi) or 0x0D (ori) → IEXE.
    - 0x04 (beq) → BEQ.
    - 0x02 (j) → JMP.
    - Anything else → pulse `illegal` and return to FETCH.
- **R-type funct map:** 0x21 ADD, 0x23 SUB, 0x24 AND, 0x25 OR, 0x2A SLT. Any other funct is illegal.
- **MEMADR:** `ALUSrcA`=1, `ALUSrcB`=10, ADD, `EXTOp`=1. Next state is MEMRD for lw, MEMWR for sw.
- **MEMRD:** `mem_req`, `MemRead`, `IorD`=1; wait for `mem_ready`, then go to MEMWB.
- **MEMWB:** `RegWrite`, `MemtoReg`=1, `RegDst`=0; then FETCH.
- **MEMWR:** `mem_req`, `MemWrite`, `IorD`=1; wait for `mem_ready`, then FETCH.
- **RTEXE:** `ALUSrcA`=1, `ALUSrcB`=00, `opcode` from funct. **RTWB:** `RegWrite`, `RegDst`=1.
- **IEXE:** `ALUSrcA`=1, `ALUSrcB`=10.
  - addi: ADD with `EXTOp`=1.
  - ori: OR with `EXTOp`=0.
- **IWB:** `RegWrite`, `RegDst`=0, and `EXTOp` held as in IEXE.
- **BEQ:** `ALUSrcA`=1, `ALUSrcB`=00, SUB, `PCSource`=01, `PCWrite`=`Zero`; then FETCH.
- **JMP:** `PCSource`=10, `PCWrite`=1; then FETCH.
- The memory handshake has no timeout. `mem_req` and its qualifiers stay constant while waiting.

## Timing
- State register updates on the rising edge of `clk`.
- Reset:
  - While `rst`=1, the state is FETCH and every output is forced to 0, including `mem_req`, `illegal` and the counters.
  - The first `mem_req` appears in the cycle `rst` deasserts.
  - Reset in any state, including mid-wait, aborts immediately. No write is issued after `rst` rises.
- Cycles per instruction with zero-wait memory (`mem_ready`=1 in the first request cycle):
  - R-type, addi, ori, sw: 4.
  - lw: 5.
  - beq, j: 3.
  - Illegal: 2.
- Each extra cycle with `mem_ready`=0 adds one cycle in FETCH, MEMRD or MEMWR.
- `mem_ready` is ignored when `mem_req`=0.

## Configuration
- `MC_CTRL_PERF_EN` defined:
  - `cycle_cnt` increments every non-reset cycle.
  - `instr_cnt` increments on the last cycle of every completed instruction; an illegal instruction counts on its DECODE cycle.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Package `mc_pkg` holds:
  - the state enum (4-bit encoding);
  - opcode constants `OP_RTYPE`, `OP_LW`, `OP_SW`, `OP_BEQ`, `OP_J`, `OP_ADDI`, `OP_ORI`;
  - funct constants;
  - ALU op codes `ALU_ADD`, `ALU_SUB`, `ALU_AND`, `ALU_OR`, `ALU_SLT`;
  - `ALUSrcB` and `PCSource` select constants.
- One sub-module: `mc_alu_dec`, a combinational funct→ALU-op decoder that also outputs a funct-valid flag used by DECODE.

## Test plan
- **Zero-wait addu:** reset, then `INSTop`=0x00, `funct`=0x21, `mem_ready`=1 → state sequence FETCH,DECODE,RTEXE,RTWB; `RegWrite`=1 with `RegDst`=1 in cycle 4; `opcode`=000 in RTEXE.
- **lw with stalled reads:** `INSTop`=0x23, `mem_ready` low 2 cycles in FETCH and 3 in MEMRD → 10 cycles total; `mem_req` held and `IRWrite` high only in the ready cycle; `MemtoReg`=1 with `RegWrite`=1 in MEMWB.
- **beq both ways:** `INSTop`=0x04 with `Zero`=1 → `PCWrite`=1 and `PCSource`=01 in cycle 3; repeat with `Zero`=0 → `PCWrite`=0; both take 3 cycles.
- **Illegal encodings:** `INSTop`=0x3F, then `INSTop`=0 with `funct`=0x00 → `illegal` pulses 1 cycle in DECODE, FETCH follows, no `RegWrite` or `MemWrite`.
- **Reset during sw:** assert `rst` in MEMWR while `mem_ready`=0 → `mem_req` and `MemWrite` drop the same cycle; after release, FETCH with `IorD`=0.
- **With `MC_CTRL_PERF_EN`:** j, ori, lw at zero wait → `instr_cnt`=3 and `cycle_cnt`=12 afterwards.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle control unit: state enum,
// instruction field constants, ALU op codes, mux selects and the control bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTEXE,
    RTWB,
    IEXE,
    IWB,
    BEQ,
    JMP
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;

  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Every datapath control driven by the FSM, so the whole set can be
  // defaulted and reset-gated in one assignment.
  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       ext_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_alu_dec.sv
// R-type funct to ALU operation decoder; funct_ok flags a supported funct.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_ok
);

  always_comb begin
    alu_op   = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADDU: alu_op = ALU_ADD;
      FN_SUBU: alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle CPU control FSM sequencing one shared memory port, ALU and
// register file. Define MC_CTRL_PERF_EN to build the instr/cycle counters.
module mc_ctrl
  import mc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  INSTop,
  input  logic [5:0]  funct,
  input  logic        Zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IorD,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic [1:0]  PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [2:0]  opcode,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        EXTOp,
  output logic        illegal,
  output logic [31:0] instr_cnt,
  output logic [31:0] cycle_cnt
);

  state_t     state, state_next;
  ctrl_t      ctrl, ctrl_out;
  logic [2:0] funct_op;
  logic       funct_ok;

  mc_alu_dec u_alu_dec (
    .funct    (funct),
    .alu_op   (funct_op),
    .funct_ok (funct_ok)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  // NOTE: every output and next_state gets a default first; a path that skips
  // an assignment would otherwise infer a latch.
  always_comb begin
    ctrl       = '0;
    state_next = state;
    case (state)
      FETCH: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
        if (mem_ready) state_next = DECODE;
      end
      DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SL2;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ext_op    = 1'b1;
        case (INSTop)
          OP_RTYPE: begin
            if (funct_ok) state_next = RTEXE;
            else begin
              ctrl.illegal = 1'b1;
              state_next   = FETCH;
            end
          end
          OP_LW, OP_SW:    state_next = MEMADR;
          OP_ADDI, OP_ORI: state_next = IEXE;
          OP_BEQ:          state_next = BEQ;
          OP_J:            state_next = JMP;
          default: begin
            ctrl.illegal = 1'b1;
            state_next   = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ext_op    = 1'b1;
        state_next     = (INSTop == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl.mem_req  = 1'b1;
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
        if (mem_ready) state_next = MEMWB;
      end
      MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        state_next      = FETCH;
      end
      MEMWR: begin
        ctrl.mem_req   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        if (mem_ready) state_next = FETCH;
      end
      RTEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = funct_op;
        state_next     = RTWB;
      end
      RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        state_next     = FETCH;
      end
      IEXE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = (INSTop == OP_ORI) ? ALU_OR : ALU_ADD;
        ctrl.ext_op    = (INSTop == OP_ADDI);
        state_next     = IWB;
      end
      IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.ext_op    = (INSTop == OP_ADDI);
        state_next     = FETCH;
      end
      BEQ: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_source = PCSRC_ALUOUT;
        ctrl.pc_write  = Zero;
        state_next     = FETCH;
      end
      JMP: begin
        ctrl.pc_source = PCSRC_JUMP;
        ctrl.pc_write  = 1'b1;
        state_next     = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  // Reset gates the outputs combinationally so a pending access or write
  // disappears in the very cycle rst rises, not at the next edge.
  assign ctrl_out = rst ? '0 : ctrl;

  assign mem_req  = ctrl_out.mem_req;
  assign MemRead  = ctrl_out.mem_read;
  assign MemWrite = ctrl_out.mem_write;
  assign IorD     = ctrl_out.iord;
  assign IRWrite  = ctrl_out.ir_write;
  assign PCWrite  = ctrl_out.pc_write;
  assign PCSource = ctrl_out.pc_source;
  assign ALUSrcA  = ctrl_out.alu_src_a;
  assign ALUSrcB  = ctrl_out.alu_src_b;
  assign opcode   = ctrl_out.alu_op;
  assign RegDst   = ctrl_out.reg_dst;
  assign MemtoReg = ctrl_out.mem_to_reg;
  assign RegWrite = ctrl_out.reg_write;
  assign EXTOp    = ctrl_out.ext_op;
  assign illegal  = ctrl_out.illegal;

`ifdef MC_CTRL_PERF_EN
  logic [31:0] instr_q, cycle_q;
  logic        instr_done;

  // Last cycle of each instruction; an illegal one retires in DECODE.
  always_comb begin
    instr_done = ctrl.illegal;
    case (state)
      MEMWB, RTWB, IWB, BEQ, JMP: instr_done = 1'b1;
      MEMWR:                      instr_done = mem_ready;
      default:                    ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (instr_done) instr_q <= instr_q + 32'd1;
    end
  end

  assign instr_cnt = instr_q;
  assign cycle_cnt = cycle_q;
`else
  assign instr_cnt = '0;
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Scoreboard bench for mc_ctrl: each driven cycle queues its expected control
// vector; a negedge monitor pops and compares against the DUT outputs.
module tb_mc_ctrl;

  typedef struct packed {
    logic       mem_req;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] opcode;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       ext_op;
    logic       illegal;
  } vec_t;

  typedef struct {
    string name;
    vec_t  v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  INSTop = '0;
  logic [5:0]  funct = '0;
  logic        Zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite;
  logic [1:0]  PCSource, ALUSrcB;
  logic        ALUSrcA, RegDst, MemtoReg, RegWrite, EXTOp, illegal;
  logic [2:0]  opcode;
  logic [31:0] instr_cnt, cycle_cnt;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  logic [5:0] cur_op = '0;
  logic [5:0] cur_funct = '0;
  vec_t act;

  mc_ctrl dut (
    .clk(clk), .rst(rst), .INSTop(INSTop), .funct(funct), .Zero(Zero),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemRead(MemRead),
    .MemWrite(MemWrite), .IorD(IorD), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .PCSource(PCSource), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .opcode(opcode), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .EXTOp(EXTOp), .illegal(illegal),
    .instr_cnt(instr_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  assign act = '{mem_req, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCSource,
                 ALUSrcA, ALUSrcB, opcode, RegDst, MemtoReg, RegWrite, EXTOp,
                 illegal};

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a control vector every cycle it is expected to.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check(e.name, 64'(act), 64'(e.v));
    end
  end

  // Expected control vectors, written from the per-state output lists.
  function automatic vec_t v_fetch(input logic r);
    vec_t v = '0;
    v.mem_req = 1; v.mem_read = 1; v.alu_src_b = 2'b01; v.ir_write = r; v.pc_write = r;
    return v;
  endfunction
  function automatic vec_t v_decode(input logic ill);
    vec_t v = '0;
    v.alu_src_b = 2'b11; v.ext_op = 1; v.illegal = ill;
    return v;
  endfunction
  function automatic vec_t v_memadr();
    vec_t v = '0;
    v.alu_src_a = 1; v.alu_src_b = 2'b10; v.ext_op = 1;
    return v;
  endfunction
  function automatic vec_t v_memrd();
    vec_t v = '0;
    v.mem_req = 1; v.mem_read = 1; v.iord = 1;
    return v;
  endfunction
  function automatic vec_t v_memwb();
    vec_t v = '0;
    v.reg_write = 1; v.mem_to_reg = 1;
    return v;
  endfunction
  function automatic vec_t v_memwr();
    vec_t v = '0;
    v.mem_req = 1; v.mem_write = 1; v.iord = 1;
    return v;
  endfunction
  function automatic vec_t v_rtexe(input logic [2:0] op);
    vec_t v = '0;
    v.alu_src_a = 1; v.opcode = op;
    return v;
  endfunction
  function automatic vec_t v_rtwb();
    vec_t v = '0;
    v.reg_write = 1; v.reg_dst = 1;
    return v;
  endfunction
  function automatic vec_t v_iexe(input logic ori);
    vec_t v = '0;
    v.alu_src_a = 1; v.alu_src_b = 2'b10; v.opcode = ori ? 3'b011 : 3'b000; v.ext_op = !ori;
    return v;
  endfunction
  function automatic vec_t v_iwb(input logic ori);
    vec_t v = '0;
    v.reg_write = 1; v.ext_op = !ori;
    return v;
  endfunction
  function automatic vec_t v_beq(input logic z);
    vec_t v = '0;
    v.alu_src_a = 1; v.opcode = 3'b001; v.pc_source = 2'b01; v.pc_write = z;
    return v;
  endfunction
  function automatic vec_t v_jmp();
    vec_t v = '0;
    v.pc_source = 2'b10; v.pc_write = 1;
    return v;
  endfunction

  // One clock cycle: drive inputs just after the edge and queue the expectation.
  task automatic cyc(input logic r, input logic rdy, input logic z, input vec_t e, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; mem_ready = rdy; Zero = z; INSTop = cur_op; funct = cur_funct;
    x.name = nm; x.v = e;
    sb.push_back(x);
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [2:0] op);
    cur_op = 6'h00; cur_funct = fn;
    cyc(0, 1, 0, v_fetch(1), "rt_fetch");
    cyc(0, 1, 0, v_decode(0), "rt_decode");
    cyc(0, 1, 0, v_rtexe(op), "rt_exe");
    cyc(0, 1, 0, v_rtwb(), "rt_wb");
  endtask

  task automatic run_lw(input int fw, input int mw);
    cur_op = 6'h23; cur_funct = 6'h15;
    for (int i = 0; i < fw; i++) cyc(0, 0, 0, v_fetch(0), "lw_fetch_wait");
    cyc(0, 1, 0, v_fetch(1), "lw_fetch");
    cyc(0, 0, 0, v_decode(0), "lw_decode");
    cyc(0, 1, 0, v_memadr(), "lw_memadr");
    for (int i = 0; i < mw; i++) cyc(0, 0, 0, v_memrd(), "lw_memrd_wait");
    cyc(0, 1, 0, v_memrd(), "lw_memrd");
    cyc(0, 1, 0, v_memwb(), "lw_memwb");
  endtask

  task automatic run_sw();
    cur_op = 6'h2B; cur_funct = 6'h00;
    cyc(0, 1, 0, v_fetch(1), "sw_fetch");
    cyc(0, 1, 0, v_decode(0), "sw_decode");
    cyc(0, 1, 0, v_memadr(), "sw_memadr");
    cyc(0, 1, 0, v_memwr(), "sw_memwr");
  endtask

  task automatic run_imm(input logic ori);
    cur_op = ori ? 6'h0D : 6'h08; cur_funct = 6'h3F;
    cyc(0, 1, 0, v_fetch(1), "imm_fetch");
    cyc(0, 1, 0, v_decode(0), "imm_decode");
    cyc(0, 1, 0, v_iexe(ori), "imm_exe");
    cyc(0, 1, 0, v_iwb(ori), "imm_wb");
  endtask

  task automatic run_beq(input logic z);
    cur_op = 6'h04; cur_funct = 6'h00;
    cyc(0, 1, z, v_fetch(1), "beq_fetch");
    cyc(0, 1, z, v_decode(0), "beq_decode");
    cyc(0, 1, z, v_beq(z), "beq_exe");
  endtask

  task automatic run_j();
    cur_op = 6'h02; cur_funct = 6'h00;
    cyc(0, 1, 0, v_fetch(1), "j_fetch");
    cyc(0, 1, 0, v_decode(0), "j_decode");
    cyc(0, 1, 0, v_jmp(), "j_exe");
  endtask

  task automatic run_illegal(input logic [5:0] op, input logic [5:0] fn);
    cur_op = op; cur_funct = fn;
    cyc(0, 1, 0, v_fetch(1), "ill_fetch");
    cyc(0, 1, 0, v_decode(1), "ill_decode");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset: all outputs 0 even though the state is FETCH.
    cyc(1, 1, 0, '0, "reset_0");
    cyc(1, 1, 0, '0, "reset_1");

    // j, ori, lw at zero wait: 3 + 4 + 5 = 12 cycles from reset release.
    run_j();
    run_imm(1'b1);
    run_lw(0, 0);
    @(posedge clk);
    #1;
`ifdef MC_CTRL_PERF_EN
    check("instr_cnt", 64'(instr_cnt), 64'd3);
    check("cycle_cnt", 64'(cycle_cnt), 64'd12);
`else
    check("instr_cnt_tied", 64'(instr_cnt), 64'd0);
    check("cycle_cnt_tied", 64'(cycle_cnt), 64'd0);
`endif
    // Cycle above started a FETCH for the held lw opcode; finish it as one.
    sb.push_back('{name: "lw2_fetch", v: v_fetch(1)});
    cyc(0, 1, 0, v_decode(0), "lw2_decode");
    cyc(0, 1, 0, v_memadr(), "lw2_memadr");
    cyc(0, 1, 0, v_memrd(), "lw2_memrd");
    cyc(0, 1, 0, v_memwb(), "lw2_memwb");

    // R-type: addu, then each remaining funct for the decoder.
    run_rtype(6'h21, 3'b000);
    run_rtype(6'h23, 3'b001);
    run_rtype(6'h24, 3'b010);
    run_rtype(6'h25, 3'b011);
    run_rtype(6'h2A, 3'b100);

    // lw with 2 stalled fetch cycles and 3 stalled read cycles: 10 cycles.
    run_lw(2, 3);

    run_beq(1'b1);
    run_beq(1'b0);
    run_imm(1'b0);
    run_sw();

    run_illegal(6'h3F, 6'h21);
    run_illegal(6'h00, 6'h00);
    run_j();

    // Reset during a stalled sw write: request drops in the cycle rst rises.
    cur_op = 6'h2B; cur_funct = 6'h00;
    cyc(0, 1, 0, v_fetch(1), "rsw_fetch");
    cyc(0, 1, 0, v_decode(0), "rsw_decode");
    cyc(0, 1, 0, v_memadr(), "rsw_memadr");
    cyc(0, 0, 0, v_memwr(), "rsw_memwr_wait");
    cyc(1, 0, 0, '0, "rsw_reset");
    cyc(1, 1, 0, '0, "rsw_reset_hold");
    cur_op = 6'h02;
    cyc(0, 0, 0, v_fetch(0), "rsw_fetch_after");
    cyc(0, 1, 0, v_fetch(1), "rsw_fetch_ready");
    cyc(0, 1, 0, v_decode(0), "rsw_j_decode");
    cyc(0, 1, 0, v_jmp(), "rsw_j_exe");

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
